// File: rtl/mbank_axil_ctrl.sv
// AXI4-Lite slave bridging to a dual-port RAM: write FSM on port A, read FSM on port B.
// Ports: clk, rst (sync, active-high); AXI-Lite AW/W/B/AR/R; RAM port A (write) and B (comb read). Optional MBANK_ADDR_CHECK_EN.
module mbank_axil_ctrl #(
  parameter int RAM_AW = 2,
  parameter int AXI_AW = 4,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AXI_AW-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [AXI_AW-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              ram_wea,
  output logic [RAM_AW-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  output logic [RAM_AW-1:0] ram_addrb,
  input  logic [DATA_W-1:0] ram_doutb
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_EXEC = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic [1:0]        wstate;
  logic [0:0]        rstate;
  logic              aw_done;
  logic              w_done;
  logic [AXI_AW-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        bresp_q;
  logic [RAM_AW-1:0] araddr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              aw_oor;
  logic              ar_oor;

`ifdef MBANK_ADDR_CHECK_EN
  assign aw_oor = |awaddr_q[AXI_AW-1:RAM_AW];
  assign ar_oor = |s_araddr[AXI_AW-1:RAM_AW];
`else
  // Upper address bits alias onto the RAM.
  logic unused_addr;
  assign unused_addr = ^{awaddr_q[AXI_AW-1:RAM_AW],
                         s_araddr[AXI_AW-1:RAM_AW]};
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif

  // Readies are masked by rst so nothing is accepted while in reset.
  assign s_awready = ~rst & (wstate == W_IDLE) & ~aw_done;
  assign s_wready  = ~rst & (wstate == W_IDLE) & ~w_done;
  assign s_arready = ~rst & (rstate == R_IDLE);

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign ar_hs = s_arvalid & s_arready;

  assign s_bvalid  = (wstate == W_RESP);
  assign s_bresp   = bresp_q;
  assign s_rvalid  = (rstate == R_DATA);
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;

  assign ram_wea   = ~rst & (wstate == W_EXEC) & ~aw_oor;
  assign ram_addra = awaddr_q[RAM_AW-1:0];
  assign ram_dina  = wdata_q;
  // Present the incoming address while idle so doutb is valid at the AR edge.
  assign ram_addrb = s_arready ? s_araddr[RAM_AW-1:0] : araddr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate   <= W_IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      bresp_q  <= OKAY;
    end else begin
      unique case (1'b1)
        (wstate == W_IDLE): begin
          if (aw_hs) begin
            awaddr_q <= s_awaddr;
            aw_done  <= 1'b1;
          end
          if (w_hs) begin
            wdata_q <= s_wdata;
            w_done  <= 1'b1;
          end
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            wstate  <= W_EXEC;
          end
        end
        (wstate == W_EXEC): begin
          bresp_q <= aw_oor ? SLVERR : OKAY;
          wstate  <= W_RESP;
        end
        (wstate == W_RESP): begin
          if (s_bready) wstate <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Capture at the AR edge reads pre-write data if port A writes the same word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rstate   <= R_IDLE;
      araddr_q <= '0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else if (rstate == R_IDLE) begin
      if (ar_hs) begin
        araddr_q <= s_araddr[RAM_AW-1:0];
        rdata_q  <= ar_oor ? '0 : ram_doutb;
        rresp_q  <= ar_oor ? SLVERR : OKAY;
        rstate   <= R_DATA;
      end
    end else if (s_rready) begin
      rstate <= R_IDLE;
    end
  end

endmodule

// File: tb/tb_mbank_axil_ctrl.sv
// Directed self-checking bench for mbank_axil_ctrl with a behavioural 4x1 RAM.
// Honours MBANK_ADDR_CHECK_EN when choosing expected responses.
module tb_mbank_axil_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] s_awaddr;
  logic       s_awvalid;
  logic       s_awready;
  logic [0:0] s_wdata;
  logic       s_wvalid;
  logic       s_wready;
  logic [1:0] s_bresp;
  logic       s_bvalid;
  logic       s_bready;
  logic [3:0] s_araddr;
  logic       s_arvalid;
  logic       s_arready;
  logic [0:0] s_rdata;
  logic [1:0] s_rresp;
  logic       s_rvalid;
  logic       s_rready;
  logic       ram_wea;
  logic [1:0] ram_addra;
  logic [0:0] ram_dina;
  logic [1:0] ram_addrb;
  logic [0:0] ram_doutb;

  logic [3:0] mem = 4'b0000;
  int         wcnt = 0;
  int         checks = 0;
  int         failures = 0;
  int         base;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wea === 1'b1) begin
      mem[ram_addra] <= ram_dina[0];
      wcnt = wcnt + 1;
    end
  end

  assign ram_doutb = mem[ram_addrb];

  mbank_axil_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_addrb (ram_addrb),
    .ram_doutb (ram_doutb)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic d);
    s_awaddr  = a;
    s_wdata   = d;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    s_bready  = 1'b1;
    tick;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    tick;
    tick;
  endtask

  initial begin
    rst       = 1'b1;
    s_awaddr  = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    s_araddr  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;

    repeat (3) tick;
    chk("rst_awready", s_awready, 0);
    chk("rst_wready", s_wready, 0);
    chk("rst_arready", s_arready, 0);
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_bresp", s_bresp, 0);
    chk("rst_rresp", s_rresp, 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_wea", ram_wea, 0);
    chk("rst_addra", ram_addra, 0);
    chk("rst_addrb", ram_addrb, 0);
    chk("rst_dina", ram_dina, 0);
    rst = 1'b0;
    #1;
    chk("rel_awready", s_awready, 1);
    chk("rel_wready", s_wready, 1);
    chk("rel_arready", s_arready, 1);

    // Same-cycle AW+W to word 2, then read back.
    base = wcnt;
    s_awaddr  = 4'h2;
    s_wdata   = 1'b1;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    s_bready  = 1'b1;
    tick;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    chk("a_wea", ram_wea, 1);
    chk("a_addra", ram_addra, 2);
    chk("a_dina", ram_dina, 1);
    chk("a_awready", s_awready, 0);
    chk("a_bvalid_exec", s_bvalid, 0);
    tick;
    chk("a_wea_off", ram_wea, 0);
    chk("a_bvalid", s_bvalid, 1);
    chk("a_bresp", s_bresp, 0);
    tick;
    chk("a_bvalid_done", s_bvalid, 0);
    chk("a_wcnt", wcnt - base, 1);
    s_araddr  = 4'h2;
    s_arvalid = 1'b1;
    #1;
    chk("a_addrb", ram_addrb, 2);
    tick;
    s_arvalid = 1'b0;
    chk("a_rvalid", s_rvalid, 1);
    chk("a_rdata", s_rdata, 1);
    chk("a_rresp", s_rresp, 0);
    s_rready = 1'b1;
    tick;
    s_rready = 1'b0;
    chk("a_rvalid_done", s_rvalid, 0);

    // W three cycles ahead of AW.
    base = wcnt;
    s_wdata  = 1'b1;
    s_wvalid = 1'b1;
    tick;
    s_wvalid = 1'b0;
    chk("b_wready", s_wready, 0);
    chk("b_awready", s_awready, 1);
    chk("b_wea0", ram_wea, 0);
    tick;
    tick;
    chk("b_wea2", ram_wea, 0);
    chk("b_nowrite", wcnt - base, 0);
    s_awaddr  = 4'h3;
    s_awvalid = 1'b1;
    tick;
    s_awvalid = 1'b0;
    chk("b_wea", ram_wea, 1);
    chk("b_addra", ram_addra, 3);
    tick;
    chk("b_bvalid", s_bvalid, 1);
    tick;
    chk("b_bvalid_done", s_bvalid, 0);
    chk("b_wcnt", wcnt - base, 1);

    // Read backpressure on word 1.
    do_write(4'h1, 1'b1);
    s_araddr  = 4'h1;
    s_arvalid = 1'b1;
    s_rready  = 1'b0;
    tick;
    s_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("c_rvalid", s_rvalid, 1);
      chk("c_rdata", s_rdata, 1);
      chk("c_arready", s_arready, 0);
      tick;
    end
    s_rready = 1'b1;
    tick;
    s_rready = 1'b0;
    chk("c_rvalid_done", s_rvalid, 0);

    // Write response backpressure.
    s_bready  = 1'b0;
    s_awaddr  = 4'h0;
    s_wdata   = 1'b1;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    tick;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("c_bvalid", s_bvalid, 1);
      chk("c_bresp", s_bresp, 0);
      chk("c_awready", s_awready, 0);
      tick;
    end
    s_bready = 1'b1;
    tick;
    chk("c_bvalid_done", s_bvalid, 0);

    // Read of word 2 captured during the write of 0 to word 2.
    s_awaddr  = 4'h2;
    s_wdata   = 1'b0;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    tick;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    chk("d_wea", ram_wea, 1);
    s_araddr  = 4'h2;
    s_arvalid = 1'b1;
    tick;
    s_arvalid = 1'b0;
    chk("d_rvalid", s_rvalid, 1);
    chk("d_rdata_old", s_rdata, 1);
    s_rready = 1'b1;
    tick;
    s_araddr  = 4'h2;
    s_arvalid = 1'b1;
    s_rready  = 1'b0;
    tick;
    s_arvalid = 1'b0;
    chk("d_rdata_new", s_rdata, 0);
    s_rready = 1'b1;
    tick;
    s_rready = 1'b0;

    // Upper address bits: range check or aliasing.
    base = wcnt;
    s_bready  = 1'b0;
    s_awaddr  = 4'h6;
    s_wdata   = 1'b1;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    tick;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    tick;
    chk("e_bvalid", s_bvalid, 1);
`ifdef MBANK_ADDR_CHECK_EN
    chk("e_wcnt", wcnt - base, 0);
    chk("e_bresp", s_bresp, 2);
`else
    chk("e_wcnt", wcnt - base, 1);
    chk("e_mem2", mem[2], 1);
    chk("e_bresp", s_bresp, 0);
`endif
    s_bready = 1'b1;
    tick;
    s_araddr  = 4'h6;
    s_arvalid = 1'b1;
    tick;
    s_arvalid = 1'b0;
    chk("e_rvalid", s_rvalid, 1);
`ifdef MBANK_ADDR_CHECK_EN
    chk("e_rdata", s_rdata, 0);
    chk("e_rresp", s_rresp, 2);
`else
    chk("e_rdata", s_rdata, 1);
    chk("e_rresp", s_rresp, 0);
`endif
    s_rready = 1'b1;
    tick;
    s_rready = 1'b0;

    // Reset mid-transaction drops the latched AW.
    base = wcnt;
    s_awaddr  = 4'h1;
    s_awvalid = 1'b1;
    tick;
    s_awvalid = 1'b0;
    chk("f_awready_held", s_awready, 0);
    rst = 1'b1;
    tick;
    chk("f_rst_awready", s_awready, 0);
    rst = 1'b0;
    #1;
    chk("f_awready", s_awready, 1);
    s_wdata  = 1'b0;
    s_wvalid = 1'b1;
    tick;
    s_wvalid = 1'b0;
    chk("f_wea", ram_wea, 0);
    tick;
    chk("f_nowrite", wcnt - base, 0);
    chk("f_bvalid", s_bvalid, 0);
    s_awaddr  = 4'h1;
    s_awvalid = 1'b1;
    tick;
    s_awvalid = 1'b0;
    chk("f_wea_done", ram_wea, 1);
    chk("f_addra", ram_addra, 1);
    tick;
    tick;
    chk("f_wcnt", wcnt - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
